// File: rtl/eth_pkg.sv
// Shared constants and state type for the Ethernet framing path.
// The receive-side CRC checker uses the same constants.
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
  localparam logic [7:0]  ETH_SFD      = 8'hD5;
  localparam logic [31:0] CRC32_POLY   = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_BODY,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } eth_gen_state_t;

endpackage

// File: rtl/eth_crc32_byte.sv
// Combinational reflected CRC-32 step over one byte, LSB first.
// The future receive checker instantiates this block as well.
module eth_crc32_byte
  import eth_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  always_comb begin
    logic [31:0] c;
    // NOTE: the running value is a blocking temporary that is assigned before any use,
    // so every path through the block writes it and no latch is inferred.
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ data[i]) ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    crc_next = c;
  end

endmodule

// File: rtl/eth_frame_gen.sv
// Ethernet transmit framer: preamble, SFD, body, zero padding and FCS,
// followed by the inter-frame gap. Output is a single valid/ready register stage.
module eth_frame_gen
  import eth_pkg::*;
#(
  parameter int MIN_BODY   = 60,
  parameter int IFG_CYCLES = 192
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pl_valid,
  input  logic [7:0] pl_data,
  input  logic       pl_last,
  output logic       pl_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       tx_last,
  input  logic       tx_ready,
  output logic       busy
);

  localparam logic [10:0]      MIN_BODY_W = 11'(MIN_BODY);
  localparam int               IFG_W      = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [IFG_W-1:0] IFG_LAST   = IFG_W'(IFG_CYCLES - 1);

  eth_gen_state_t   state;
  logic [2:0]       pre_cnt;
  logic [10:0]      body_cnt;
  logic [10:0]      body_cnt_inc;
  logic [2:0]       fcs_idx;
  logic [IFG_W-1:0] ifg_cnt;
  logic [31:0]      crc;
  logic [31:0]      crc_next;
  logic [31:0]      crc_inv;
  logic [7:0]       crc_byte;
  logic [7:0]       fcs_byte;
  logic             slot_free;

  assign slot_free    = !tx_valid || tx_ready;
  // Body bytes pass straight into the output register, so the upstream
  // handshake follows the output slot combinationally.
  assign pl_ready     = (state == ST_BODY) && slot_free;
  assign busy         = (state != ST_IDLE);
  assign body_cnt_inc = (&body_cnt) ? body_cnt : body_cnt + 11'd1;
  assign crc_byte     = (state == ST_BODY) ? pl_data : 8'h00;
  assign crc_inv      = ~crc;

  always_comb begin
    case (fcs_idx[1:0])
      2'd0:    fcs_byte = crc_inv[7:0];
      2'd1:    fcs_byte = crc_inv[15:8];
      2'd2:    fcs_byte = crc_inv[23:16];
      default: fcs_byte = crc_inv[31:24];
    endcase
  end

  eth_crc32_byte u_crc (
    .crc      (crc),
    .data     (crc_byte),
    .crc_next (crc_next)
  );

  // NOTE: all state and output registers use non-blocking assignments so every
  // branch below sees the values from the start of the cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pre_cnt  <= '0;
      body_cnt <= '0;
      fcs_idx  <= '0;
      ifg_cnt  <= '0;
      crc      <= CRC32_INIT;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      tx_last  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            tx_valid <= 1'b1;
            tx_data  <= ETH_PREAMBLE;
            tx_last  <= 1'b0;
            pre_cnt  <= 3'd1;
            state    <= ST_PRE;
          end
        end
        ST_PRE: begin
          if (slot_free) begin
            tx_valid <= 1'b1;
            tx_data  <= ETH_PREAMBLE;
            if (pre_cnt == 3'd6) state <= ST_SFD;
            else                 pre_cnt <= pre_cnt + 3'd1;
          end
        end
        ST_SFD: begin
          if (slot_free) begin
            tx_valid <= 1'b1;
            tx_data  <= ETH_SFD;
            crc      <= CRC32_INIT;
            body_cnt <= '0;
            state    <= ST_BODY;
          end
        end
        ST_BODY: begin
          if (slot_free) begin
            if (pl_valid) begin
              tx_valid <= 1'b1;
              tx_data  <= pl_data;
              crc      <= crc_next;
              body_cnt <= body_cnt_inc;
              if (pl_last) begin
                fcs_idx <= '0;
                state   <= (body_cnt_inc < MIN_BODY_W) ? ST_PAD : ST_FCS;
              end
            end else begin
              tx_valid <= 1'b0;
            end
          end
        end
        ST_PAD: begin
          if (slot_free) begin
            tx_valid <= 1'b1;
            tx_data  <= 8'h00;
            crc      <= crc_next;
            body_cnt <= body_cnt_inc;
            if (body_cnt_inc >= MIN_BODY_W) state <= ST_FCS;
          end
        end
        ST_FCS: begin
          // The CRC register is frozen here; fcs_idx == 4 means the last byte is being accepted.
          if (slot_free) begin
            if (fcs_idx == 3'd4) begin
              tx_valid <= 1'b0;
              tx_last  <= 1'b0;
              ifg_cnt  <= '0;
              state    <= ST_IFG;
            end else begin
              tx_valid <= 1'b1;
              tx_data  <= fcs_byte;
              tx_last  <= (fcs_idx == 3'd3);
              fcs_idx  <= fcs_idx + 3'd1;
            end
          end
        end
        ST_IFG: begin
          if (ifg_cnt == IFG_LAST) state <= ST_IDLE;
          else                     ifg_cnt <= ifg_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_frame_gen.sv
// Self-checking bench for eth_frame_gen: a frame-level byte model drives a
// per-cycle output comparison, plus literal vectors that pin the model.
module tb_eth_frame_gen;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } exp_t;
  typedef logic [7:0] byte_q_t[$];

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, pl_valid, pl_last, pl_ready, tx_valid, tx_last, tx_ready, busy;
  logic [7:0] pl_data, tx_data;
  logic       s_start, s_pl_valid, s_pl_last, s_pl_ready, s_tx_valid, s_tx_last, s_busy;
  logic [7:0] s_pl_data, s_tx_data;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int ready_pct = 100;
  int gap_pct = 0;

  exp_t       exp_q[$];
  int         mon_idx = 0;
  int         last_len = 0;
  int         last_cyc = 0;
  bit         ifg_active = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_last = 1'b0;

  eth_frame_gen #(.MIN_BODY(60), .IFG_CYCLES(192)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .pl_valid(pl_valid), .pl_data(pl_data), .pl_last(pl_last), .pl_ready(pl_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last), .tx_ready(tx_ready),
    .busy(busy)
  );

  eth_frame_gen #(.MIN_BODY(0), .IFG_CYCLES(192)) std_dut (
    .clk(clk), .rst_n(rst_n), .start(s_start),
    .pl_valid(s_pl_valid), .pl_data(s_pl_data), .pl_last(s_pl_last), .pl_ready(s_pl_ready),
    .tx_valid(s_tx_valid), .tx_data(s_tx_data), .tx_last(s_tx_last), .tx_ready(1'b1),
    .busy(s_busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = ($urandom_range(99) < ready_pct);
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  function automatic logic [31:0] crc32_sw(input byte_q_t q);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      c = c ^ {24'h0, q[i]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic byte_q_t model_frame(input byte_q_t body, input int min_len);
    byte_q_t     padded;
    byte_q_t     q;
    logic [31:0] f;
    padded = body;
    while (padded.size() < min_len) padded.push_back(8'h00);
    f = crc32_sw(padded);
    for (int i = 0; i < 7; i++) q.push_back(8'h55);
    q.push_back(8'hD5);
    foreach (padded[i]) q.push_back(padded[i]);
    for (int k = 0; k < 4; k++) q.push_back(f[8*k +: 8]);
    return q;
  endfunction

  function automatic byte_q_t rand_body(input int n);
    byte_q_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  function automatic void push_frame(input byte_q_t body);
    byte_q_t q;
    q = model_frame(body, 60);
    foreach (q[i]) exp_q.push_back('{data: q[i], last: (i == q.size() - 1)});
  endfunction

  // Per-cycle compare of the main DUT against the expected byte stream.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (prev_stall) begin
        check("hold_valid", tx_valid, 1);
        check("hold_data", tx_data, prev_data);
        check("hold_last", tx_last, prev_last);
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      prev_last  = tx_last;
      if (ifg_active && cyc == last_cyc + 192) check("ifg_busy_held", busy, 1);
      if (ifg_active && cyc == last_cyc + 193) begin
        check("ifg_busy_fall", busy, 0);
        ifg_active = 1'b0;
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_tx_valid", tx_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("tx_data", tx_data, e.data);
          check("tx_last", tx_last, e.last);
          mon_idx++;
          if (e.last) begin
            last_len   = mon_idx;
            mon_idx    = 0;
            last_cyc   = cyc;
            ifg_active = 1'b1;
          end
        end
      end
    end
  end

  task automatic drive_frame(input byte_q_t body, input bit pulse_mid);
    int i = 0;
    int guard = 0;
    @(negedge clk);
    while (busy && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check("idle_before_start", busy, 0);
    push_frame(body);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("start_busy", busy, 1);
    check("start_valid", tx_valid, 1);
    check("start_preamble", tx_data, 8'h55);
    @(posedge clk);
    #1;
    guard = 0;
    while (i < body.size() && guard < 20000) begin
      start = pulse_mid && (i == body.size() / 2);
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        pl_valid = 1'b0;
        pl_last  = 1'b0;
        pl_data  = 8'($urandom);
      end else begin
        pl_valid = 1'b1;
        pl_data  = body[i];
        pl_last  = (i == body.size() - 1);
      end
      @(negedge clk);
      if (pl_valid && pl_ready) i++;
      @(posedge clk);
      #1;
      guard++;
    end
    start    = 1'b0;
    pl_valid = 1'b0;
    pl_last  = 1'b0;
    if (i != body.size()) check("body_accept_timeout", i, body.size());
  endtask

  task automatic wait_done();
    int g = 0;
    while ((exp_q.size() != 0 || ifg_active || busy) && g < 10000) begin
      @(negedge clk);
      g++;
    end
    check("frame_complete", (exp_q.size() == 0 && !ifg_active && !busy), 1);
  endtask

  initial begin
    byte_q_t    b;
    byte_q_t    m;
    logic [7:0] std_exp[21];
    logic [7:0] got[$];
    logic       got_last[$];
    int         nbad;
    int         nzero;
    int         g;
    int         si;
    bit         done;
    int         sizes[6];

    start = 0; pl_valid = 0; pl_data = 0; pl_last = 0;
    s_start = 0; s_pl_valid = 0; s_pl_data = 0; s_pl_last = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {busy, pl_ready, tx_valid, tx_last, tx_data}, 0);
    check("reset_outputs_std", {s_busy, s_pl_ready, s_tx_valid, s_tx_last, s_tx_data}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) begin
      @(negedge clk);
      check("idle_outputs", {busy, pl_ready, tx_valid, tx_last, tx_data}, 0);
    end

    // Pin the model with the standard check value and literal frame shapes.
    for (int i = 0; i < 9; i++) b.push_back(8'(8'h31 + i));
    check("model_crc_check_value", crc32_sw(b), 32'hCBF43926);
    for (int i = 0; i < 7; i++) std_exp[i] = 8'h55;
    std_exp[7] = 8'hD5;
    for (int i = 0; i < 9; i++) std_exp[8+i] = 8'(8'h31 + i);
    std_exp[17] = 8'h26; std_exp[18] = 8'h39; std_exp[19] = 8'hF4; std_exp[20] = 8'hCB;
    m = model_frame(b, 0);
    check("model_std_len", m.size(), 21);
    nbad = 0;
    for (int i = 0; i < 21 && i < m.size(); i++) if (m[i] != std_exp[i]) nbad++;
    check("model_std_bytes", nbad, 0);
    m = model_frame(rand_body(14), 60);
    check("model_pad_len", m.size(), 72);
    nzero = 0;
    for (int i = 22; i < 68 && i < m.size(); i++) if (m[i] == 8'h00) nzero++;
    check("model_pad_zeros", nzero, 46);

    // Standard vector on the MIN_BODY=0 instance with tx_ready tied high.
    done = 1'b0;
    fork
      begin
        @(negedge clk);
        s_start = 1'b1;
        @(posedge clk);
        #1 s_start = 1'b0;
        si = 0; g = 0;
        s_pl_valid = 1'b1;
        while (si < 9 && g < 200) begin
          s_pl_data = std_exp[8+si];
          s_pl_last = (si == 8);
          @(negedge clk);
          if (s_pl_ready) si++;
          @(posedge clk);
          #1;
          g++;
        end
        s_pl_valid = 1'b0;
        s_pl_last  = 1'b0;
      end
      begin
        for (int w = 0; w < 400 && !done; w++) begin
          @(negedge clk);
          if (s_tx_valid) begin
            got.push_back(s_tx_data);
            got_last.push_back(s_tx_last);
            if (s_tx_last) done = 1'b1;
          end
        end
        check("std_frame_done", done, 1);
        if (done) begin
          for (int k = 1; k <= 193; k++) begin
            @(negedge clk);
            if (k == 192) check("std_busy_ifg", s_busy, 1);
            if (k == 193) check("std_busy_end", s_busy, 0);
          end
        end
      end
    join
    check("std_len", got.size(), 21);
    for (int i = 0; i < got.size() && i < 21; i++) begin
      check("std_byte", got[i], std_exp[i]);
      check("std_last", got_last[i], (i == 20));
    end

    // Padding: 14-byte body, no stalls.
    ready_pct = 100; gap_pct = 0;
    drive_frame(rand_body(14), 1'b0);
    wait_done();
    check("pad_frame_len", last_len, 72);

    // Random backpressure and upstream gaps around the padding boundary.
    ready_pct = 30; gap_pct = 30;
    sizes = '{1, 59, 60, 61, 100, 0};
    foreach (sizes[k]) begin
      si = (sizes[k] == 0) ? $urandom_range(120, 1) : sizes[k];
      drive_frame(rand_body(si), 1'b0);
      wait_done();
      check("frame_len", last_len, ((si < 60) ? 60 : si) + 12);
    end

    // Start during BODY and during IFG is ignored; first IDLE cycle starts the next frame.
    drive_frame(rand_body(20), 1'b1);
    g = 0;
    while (!ifg_active && g < 5000) begin
      @(negedge clk);
      g++;
    end
    check("reached_ifg", ifg_active, 1);
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drive_frame(rand_body(8), 1'b0);
    wait_done();
    check("after_ifg_frame_len", last_len, 72);

    // Reset while FCS byte 2 sits in the output slot.
    ready_pct = 100; gap_pct = 0;
    repeat (2) @(negedge clk);
    b = rand_body(10);
    m = model_frame(b, 60);
    drive_frame(b, 1'b0);
    g = 0;
    do begin
      @(posedge clk);
      #2;
      g++;
    end while (!(tx_valid && mon_idx == 69) && g < 500);
    check("fcs2_in_slot", tx_data, m[69]);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {busy, pl_ready, tx_valid, tx_last, tx_data}, 0);
    exp_q.delete();
    mon_idx = 0;
    ifg_active = 1'b0;
    prev_stall = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ready_pct = 30; gap_pct = 30;
    drive_frame(rand_body(25), 1'b0);
    wait_done();
    check("post_reset_frame_len", last_len, 72);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
